// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gol_pkg
// Description : Shared state encodings and helpers for the Game of Life
//               generation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    typedef logic [1:0] gol_state_t;

    localparam gol_state_t c_ST_SEED  = 2'd0;
    localparam gol_state_t c_ST_RUN   = 2'd1;
    localparam gol_state_t c_ST_PAUSE = 2'd2;
    localparam gol_state_t c_ST_STEP  = 2'd3;

    localparam int c_FRAME_CNT_W = 3;

    // Last frame index of a 2^speed frame period.
    function automatic logic [c_FRAME_CNT_W-1:0] hold_limit(input logic [1:0] speed);
        return c_FRAME_CNT_W'((4'd1 << speed) - 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gol_frame_div.sv
`default_nettype none
// ============================================================================
// Module      : gol_frame_div
// Description : Frame divider for RUN mode; flags when the next frame evolves.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_frame_div
    import gol_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_adv,
    input  logic [1:0] i_speed,
    output logic       o_is_evolve
);

    logic [c_FRAME_CNT_W-1:0] r_frame_cnt;

    // ">=" rather than "==" so lowering speed mid-period cannot strand the counter.
    assign o_is_evolve = (r_frame_cnt >= hold_limit(i_speed));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (i_clr) begin
            r_frame_cnt <= '0;
        end else if (i_adv) begin
            r_frame_cnt <= o_is_evolve ? '0 : r_frame_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gol_sched.sv
`default_nettype none
// ============================================================================
// Module      : gol_sched
// Description : Frame-synchronous scheduler for the Game of Life board:
//               seeding, run/pause/single-step control and generation count.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_sched
    import gol_pkg::*;
#(
    parameter int SEED_FRAMES = 2,
    parameter int GEN_W       = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             vga_da,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_seed,
    input  logic [1:0]       speed,
    output logic             gol_ena,
    output logic             gol_seed,
    output logic             gol_hold,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state
);

    localparam int c_SEED_W = (SEED_FRAMES > 1) ? $clog2(SEED_FRAMES) : 1;
    localparam logic [c_SEED_W-1:0] c_SEED_LAST = c_SEED_W'(SEED_FRAMES - 1);

    gol_state_t          r_state;
    gol_state_t          w_state_nxt;
    logic                r_run_mode;
    logic                r_seed_p;
    logic                r_run_p;
    logic                r_step_p;
    logic [c_SEED_W-1:0] r_seed_cnt;
    logic [GEN_W-1:0]    r_gen_count;
    logic                r_hold;
    logic                r_seed;

    logic w_seed_p;
    logic w_run_p;
    logic w_step_p;
    logic w_run_mode_nxt;
    logic w_seed_last;
    logic w_evolve_end;
    logic w_is_evolve;
    logic w_div_clr;
    logic w_div_adv;
    logic w_hold_nxt;
    logic w_seed_nxt;

    // A button arriving on the frame_start cycle itself is still honoured.
    assign w_seed_p       = r_seed_p | btn_seed;
    assign w_run_p        = r_run_p ^ btn_run;
    assign w_step_p       = r_step_p | btn_step;
    assign w_run_mode_nxt = r_run_mode ^ w_run_p;
    assign w_seed_last    = (r_seed_cnt == c_SEED_LAST);
    assign w_evolve_end   = ((r_state == c_ST_RUN) && !r_hold) || (r_state == c_ST_STEP);

    gol_frame_div u_frame_div (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_div_clr),
        .i_adv       (w_div_adv),
        .i_speed     (speed),
        .o_is_evolve (w_is_evolve)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_SEED;
            r_hold   <= 1'b0;
            r_seed   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_seed   <= w_seed_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            if (w_seed_p) begin
                w_state_nxt = c_ST_SEED;
            end else begin
                case (r_state)
                    c_ST_SEED: begin
                        if (w_seed_last) begin
                            w_state_nxt = w_run_mode_nxt ? c_ST_RUN : c_ST_PAUSE;
                        end
                    end
                    c_ST_RUN: begin
                        if (!w_run_mode_nxt) begin
                            w_state_nxt = c_ST_PAUSE;
                        end
                    end
                    c_ST_PAUSE: begin
                        if (w_run_mode_nxt) begin
                            w_state_nxt = c_ST_RUN;
                        end else if (w_step_p && !w_run_p) begin
                            w_state_nxt = c_ST_STEP;
                        end
                    end
                    default: begin
                        w_state_nxt = w_run_mode_nxt ? c_ST_RUN : c_ST_PAUSE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_hold_nxt = r_hold;
        w_seed_nxt = r_seed;
        w_div_clr  = 1'b0;
        w_div_adv  = 1'b0;
        if (frame_start) begin
            // Any frame that is not a continuation of RUN restarts the period.
            w_div_clr  = (w_state_nxt != c_ST_RUN) || (r_state != c_ST_RUN);
            w_div_adv  = !w_div_clr;
            w_seed_nxt = (w_state_nxt == c_ST_SEED);
            case (w_state_nxt)
                c_ST_RUN:   w_hold_nxt = (r_state == c_ST_RUN) ? !w_is_evolve : 1'b0;
                c_ST_PAUSE: w_hold_nxt = 1'b1;
                default:    w_hold_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_mode  <= 1'b1;
            r_seed_p    <= 1'b0;
            r_run_p     <= 1'b0;
            r_step_p    <= 1'b0;
            r_seed_cnt  <= '0;
            r_gen_count <= '0;
        end else if (frame_start) begin
            r_seed_p <= 1'b0;
            r_run_p  <= 1'b0;
            r_step_p <= 1'b0;
            if (w_run_p) begin
                r_run_mode <= ~r_run_mode;
            end
            if (w_seed_p || (r_state != c_ST_SEED) || w_seed_last) begin
                r_seed_cnt <= '0;
            end else begin
                r_seed_cnt <= r_seed_cnt + 1'b1;
            end
            if (w_seed_p) begin
                r_gen_count <= '0;
            end else if (w_evolve_end) begin
                r_gen_count <= r_gen_count + 1'b1;
            end
        end else begin
            r_seed_p <= w_seed_p;
            r_run_p  <= w_run_p;
            r_step_p <= w_step_p;
        end
    end

    assign gol_ena   = vga_da;
    assign gol_seed  = r_seed;
    assign gol_hold  = r_hold;
    assign gen_count = r_gen_count;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gol_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gol_sched
// Description : Self-checking bench for gol_sched against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_sched;

    localparam int SEED_FRAMES = 2;
    localparam int GEN_W       = 4;
    localparam int FRAME_LEN   = 8;
    localparam int M_SEED = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             vga_da;
    logic             btn_run;
    logic             btn_step;
    logic             btn_seed;
    logic [1:0]       speed;
    logic             gol_ena;
    logic             gol_seed;
    logic             gol_hold;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       state;

    int total = 0;
    int bad   = 0;

    int m_state, m_seed_left, m_k, m_gen;
    bit m_run_mode, m_seed_p, m_run_p, m_step_p;
    bit pat [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    gol_sched #(
        .SEED_FRAMES (SEED_FRAMES),
        .GEN_W       (GEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .vga_da      (vga_da),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .btn_seed    (btn_seed),
        .speed       (speed),
        .gol_ena     (gol_ena),
        .gol_seed    (gol_seed),
        .gol_hold    (gol_hold),
        .gen_count   (gen_count),
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: one call per rising edge, using the inputs held across that edge.
    task automatic model_edge();
        bit sp, rp, tp;
        if (rst) begin
            m_state = M_SEED; m_seed_left = SEED_FRAMES; m_run_mode = 1'b1;
            m_seed_p = 1'b0; m_run_p = 1'b0; m_step_p = 1'b0; m_k = 0; m_gen = 0;
        end else if (!frame_start) begin
            m_seed_p = m_seed_p | btn_seed;
            m_run_p  = m_run_p ^ btn_run;
            m_step_p = m_step_p | btn_step;
        end else begin
            sp = m_seed_p | btn_seed;
            rp = m_run_p ^ btn_run;
            tp = m_step_p | btn_step;
            if (m_state == M_STEP || (m_state == M_RUN && m_k == 0))
                m_gen = (m_gen + 1) % (1 << GEN_W);
            if (rp) m_run_mode = !m_run_mode;
            if (sp) begin
                m_state = M_SEED; m_seed_left = SEED_FRAMES; m_gen = 0;
            end else begin
                case (m_state)
                    M_SEED: begin
                        m_seed_left--;
                        if (m_seed_left == 0) begin
                            m_state = m_run_mode ? M_RUN : M_PAUSE; m_k = 0;
                        end
                    end
                    M_RUN: begin
                        if (!m_run_mode) m_state = M_PAUSE;
                        else m_k = (m_k >= (1 << speed) - 1) ? 0 : m_k + 1;
                    end
                    M_PAUSE: begin
                        if (m_run_mode) begin m_state = M_RUN; m_k = 0; end
                        else if (tp && !rp) m_state = M_STEP;
                    end
                    default: begin
                        m_state = m_run_mode ? M_RUN : M_PAUSE; m_k = 0;
                    end
                endcase
            end
            m_seed_p = 1'b0; m_run_p = 1'b0; m_step_p = 1'b0;
        end
    endtask

    task automatic tick();
        bit exp_hold;
        @(posedge clk);
        model_edge();
        #1;
        exp_hold = (m_state == M_PAUSE) || (m_state == M_RUN && m_k != 0);
        check("ena",   32'(gol_ena),   32'(vga_da));
        check("state", 32'(state),     32'(m_state));
        check("hold",  32'(gol_hold),  32'(exp_hold));
        check("seed",  32'(gol_seed),  32'(m_state == M_SEED));
        check("gen",   32'(gen_count), 32'(m_gen));
        vga_da = 1'($urandom_range(0, 1));
    endtask

    // One frame; btns = {seed, step, run} pulsed at cycles a1 and a2 (-1 = none).
    task automatic run_frame(input int a1, input bit [2:0] b1, input int a2, input bit [2:0] b2);
        for (int c = 0; c < FRAME_LEN - 1; c++) begin
            if (c == a1) {btn_seed, btn_step, btn_run} = b1;
            if (c == a2) {btn_seed, btn_step, btn_run} = b2;
            tick();
            {btn_seed, btn_step, btn_run} = 3'b000;
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; vga_da = 1'b0; speed = 2'd2;
        btn_run = 1'b0; btn_step = 1'b0; btn_seed = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_seed",  32'(gol_seed), 32'd1);
        check("rst_hold",  32'(gol_hold), 32'd0);
        check("rst_gen",   32'(gen_count), 32'd0);
        rst = 1'b0;

        // Two seed frames, then RUN with an evolve frame.
        run_frame(-1, 3'b000, -1, 3'b000);
        check("seed_f2", 32'(gol_seed), 32'd1);
        run_frame(-1, 3'b000, -1, 3'b000);
        check("run_state", 32'(state), 32'd1);
        check("run_hold0", 32'(gol_hold), 32'd0);
        check("run_gen0",  32'(gen_count), 32'd0);

        // speed=2 hold pattern.
        for (int i = 0; i < 8; i++) begin
            check("pat_hold", 32'(gol_hold), 32'(pat[i]));
            run_frame(-1, 3'b000, -1, 3'b000);
        end
        check("pat_gen", 32'(gen_count), 32'd2);

        // Two run pulses in one frame cancel.
        run_frame(1, 3'b001, 5, 3'b001);
        check("cancel_state", 32'(state), 32'd1);

        // Pause then single step.
        run_frame(3, 3'b001, -1, 3'b000);
        check("pause_state", 32'(state), 32'd2);
        check("pause_hold",  32'(gol_hold), 32'd1);
        run_frame(2, 3'b010, -1, 3'b000);
        check("step_state", 32'(state), 32'd3);
        check("step_hold",  32'(gol_hold), 32'd0);
        run_frame(-1, 3'b000, -1, 3'b000);
        check("step_back", 32'(state), 32'd2);
        check("step_gen",  32'(gen_count), 32'd4);

        // Back to RUN, then seed+run together.
        run_frame(1, 3'b001, -1, 3'b000);
        run_frame(4, 3'b101, -1, 3'b000);
        check("reseed_state", 32'(state), 32'd0);
        check("reseed_gen",   32'(gen_count), 32'd0);
        run_frame(-1, 3'b000, -1, 3'b000);
        run_frame(-1, 3'b000, -1, 3'b000);
        check("reseed_exit", 32'(state), 32'd2);

        // Reset in the middle of a STEP frame.
        run_frame(2, 3'b010, -1, 3'b000);
        check("pre_rst_step", 32'(state), 32'd3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_step_state", 32'(state), 32'd0);
        check("rst_step_gen",   32'(gen_count), 32'd0);

        // Generation counter wrap at GEN_W=4, evolving every frame.
        speed = 2'd0;
        run_frame(-1, 3'b000, -1, 3'b000);
        run_frame(-1, 3'b000, -1, 3'b000);
        for (int i = 1; i <= 16; i++) begin
            run_frame(-1, 3'b000, -1, 3'b000);
            if (i == 15) check("wrap_15", 32'(gen_count), 32'd15);
        end
        check("wrap_0", 32'(gen_count), 32'd0);

        // Randomized operation.
        for (int f = 0; f < 120; f++) begin
            bit [2:0] b1, b2;
            if ($urandom_range(0, 9) == 0) speed = 2'($urandom_range(0, 3));
            b1 = {($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            b2 = {1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0)};
            run_frame($urandom_range(0, 2), b1, $urandom_range(3, FRAME_LEN - 2), b2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gol_sched.md
GOL_SCHED -- requirements
Module: gol_sched

Interface
REQ-001 The block SHALL have parameter SEED_FRAMES, default 2: number of whole frames the board is seeded from the LFSR.
REQ-002 The block SHALL have parameter GEN_W, default 16: width of the generation counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock (VGA pixel clock); all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse when the vertical counter wraps to 0.
REQ-006 The block SHALL have port vga_da, input, 1 bit: display-area flag from the vga timing block.
REQ-007 The block SHALL have port btn_run, input, 1 bit: one-cycle pulse that toggles run mode (already debounced).
REQ-008 The block SHALL have port btn_step, input, 1 bit: one-cycle pulse requesting a single generation.
REQ-009 The block SHALL have port btn_seed, input, 1 bit: one-cycle pulse requesting a reseed.
REQ-010 The block SHALL have port speed, input, 2 bits: in RUN, one generation every 2^speed frames.
REQ-011 The block SHALL have port gol_ena, output, 1 bit: shift enable to the board.
REQ-012 The block SHALL have port gol_seed, output, 1 bit: seed select to the board (LFSR replaces row2 head).
REQ-013 The block SHALL have port gol_hold, output, 1 bit: board recirculates the current cell instead of newgen.
REQ-014 The block SHALL have port gen_count, output, GEN_W bits: generations computed since the last seed.
REQ-015 The block SHALL have port state, output, 2 bits: SEED=0, RUN=1, PAUSE=2, STEP=3.

Function
REQ-016 gol_ena SHALL equal vga_da combinationally, in every state, so that the display never freezes.
REQ-017 The FSM SHALL have states SEED, RUN, PAUSE and STEP; state changes SHALL occur only in the cycle frame_start=1.
REQ-018 Button pulses SHALL be latched into pending flags (seed_p, run_p, step_p) on any cycle, and consumed or cleared at the next frame_start.
REQ-019 run_mode SHALL be a flag toggled by each consumed run_p; two btn_run pulses within one frame SHALL cancel.
REQ-020 Priority at frame_start SHALL be: seed_p, then run_p, then step_p.
REQ-021 A pending seed_p SHALL cause a transition to SEED from any state, clear frame_cnt, clear gen_count, and discard step_p.
REQ-022 SEED SHALL assert gol_seed=1 and gol_hold=0 for exactly SEED_FRAMES frames, counted in seed_cnt.
REQ-023 SEED SHALL then exit to RUN if run_mode=1, else to PAUSE; gen_count stays 0.
REQ-024 RUN SHALL run a frame counter frame_cnt (3 bits).
REQ-025 The first frame after entering RUN SHALL be an evolve frame (gol_hold=0).
REQ-026 The next 2^speed-1 frames in RUN SHALL be hold frames (gol_hold=1).
REQ-027 frame_cnt SHALL wrap when frame_cnt >= 2^speed-1, so a speed change takes effect at the next frame_start without a lockup.
REQ-028 RUN SHALL exit to PAUSE when the consumed run_p clears run_mode.
REQ-029 PAUSE SHALL drive gol_hold=1 and gol_seed=0; it SHALL go to RUN when run_p sets run_mode, else to STEP when step_p is pending.
REQ-030 STEP SHALL last exactly one frame with gol_hold=0, then return to PAUSE; seed_p or run_p pending at that edge SHALL apply normally.
REQ-031 step_p SHALL be discarded in RUN and SEED, and when run_p is consumed in the same frame_start.
REQ-032 gen_count SHALL increment at the frame_start that ends each evolve frame (RUN with hold=0, or STEP), with modulo 2^GEN_W wrap-around.
REQ-033 gol_hold and gol_seed SHALL be registered, update only at frame_start, and be constant for the whole frame.

Reset
REQ-034 rst=1 SHALL force state=SEED and seed_cnt=0.
REQ-035 rst=1 SHALL force run_mode=1, clear all pending flags, and set frame_cnt=0 and gen_count=0.
REQ-036 During rst, outputs SHALL be gol_seed=1, gol_hold=0, and gol_ena=vga_da.
REQ-037 Reset applied mid-frame SHALL abort any evolve or step without incrementing gen_count.

Structure
REQ-038 A shared package gol_pkg SHALL hold the state enumeration and the SEED/RUN/PAUSE/STEP encodings.
REQ-039 One sub-module, gol_frame_div (frame_cnt plus speed compare, output is_evolve), SHALL be used.

Verification
REQ-040 rst for 3 cycles, then 2 frame_start pulses -> gol_seed=1 for both frames, then state=RUN, gol_hold=0, gen_count=0.
REQ-041 RUN with speed=2 for 8 frames -> hold pattern 0,1,1,1,0,1,1,1; gen_count=2.
REQ-042 btn_run mid-frame -> state=PAUSE at next frame_start, gol_hold=1; then btn_step -> exactly one hold=0 frame, gen_count+1, back to PAUSE.
REQ-043 btn_seed and btn_run in the same cycle while in RUN -> SEED at next frame_start, gen_count=0, exit to PAUSE after 2 frames.
REQ-044 GEN_W=4 with 16 evolve frames -> gen_count wraps 15->0.
REQ-045 rst asserted mid-STEP -> state=SEED next cycle, gen_count unchanged (0), gol_ena tracks vga_da throughout.
